ascon_fsm_encrypt: RTL and testbench

Control state machine for the ASCON-128 encryption datapath: sequences initialization (p12), one associated-data block (p6), NB_BLOCKS plaintext blocks and finalization (p12), and emits tag and ciphertext strobes. It is the transmit-side counterpart of the decryption FSM. It drives the same permutation, XOR-begin/XOR-end and register-enable controls. Unlike the decryption FSM, it owns its round and block counters and exposes a ready/valid input handshake.

---
 rtl/ascon_fsm_encrypt.sv | 146 ++++++++++++++
 tb/tb_ascon_fsm_encrypt.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ascon_fsm_encrypt.sv
// ascon_fsm_encrypt: ASCON-128 encryption control FSM with ready/valid input handshake.
// Optional abort path enabled by defining FSM_ENC_ABORT_EN.
module ascon_fsm_encrypt #(
    parameter int NB_BLOCKS = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       data_valid_i,
`ifdef FSM_ENC_ABORT_EN
    input  logic       abort_i,
`endif
    output logic       data_ready_o,
    output logic [3:0] round_o,
    output logic       init_state_o,
    output logic       state_we_o,
    output logic       xor_begin_data_o,
    output logic       xor_begin_key_o,
    output logic       xor_end_key_o,
    output logic       xor_end_lsb_o,
    output logic       cipher_we_o,
    output logic       cipher_valid_o,
    output logic       tag_we_o,
    output logic       tag_valid_o,
    output logic       end_o
);
    typedef enum logic [3:0] {
        IDLE, INIT_LOAD, INIT_PERM, WAIT_AD, AD_PERM, WAIT_PT, PT_PERM, FINAL_PERM, DONE
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] round_q, round_d;
    logic [3:0] blk_q, blk_d;
    logic       last;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            round_q <= 4'd0;
            blk_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            blk_q   <= blk_d;
        end
    end

    assign round_o = round_q;
    assign last    = round_q == 4'd11;

    // Round counter returns to 0 when a permutation completes, so waits and IDLE show round 0.
    always_comb begin
        state_d          = state_q;
        round_d          = round_q;
        blk_d            = blk_q;
        data_ready_o     = 1'b0;
        init_state_o     = 1'b0;
        state_we_o       = 1'b0;
        xor_begin_data_o = 1'b0;
        xor_begin_key_o  = 1'b0;
        xor_end_key_o    = 1'b0;
        xor_end_lsb_o    = 1'b0;
        cipher_we_o      = 1'b0;
        cipher_valid_o   = 1'b0;
        tag_we_o         = 1'b0;
        tag_valid_o      = 1'b0;
        end_o            = 1'b0;
        case (state_q)
            IDLE: begin
                round_d = 4'd0;
                blk_d   = 4'd0;
                state_d = start_i ? INIT_LOAD : IDLE;
            end
            INIT_LOAD: begin
                init_state_o = 1'b1;
                state_we_o   = 1'b1;
                round_d      = 4'd0;
                state_d      = INIT_PERM;
            end
            INIT_PERM: begin
                state_we_o    = 1'b1;
                xor_end_key_o = last;
                round_d       = last ? 4'd0 : round_q + 4'd1;
                state_d       = last ? WAIT_AD : INIT_PERM;
            end
            WAIT_AD: begin
                data_ready_o = 1'b1;
                round_d      = data_valid_i ? 4'd6 : round_q;
                state_d      = data_valid_i ? AD_PERM : WAIT_AD;
            end
            AD_PERM: begin
                state_we_o       = 1'b1;
                xor_begin_data_o = round_q == 4'd6;
                xor_end_lsb_o    = last;
                round_d          = last ? 4'd0 : round_q + 4'd1;
                blk_d            = last ? 4'd0 : blk_q;
                state_d          = last ? WAIT_PT : AD_PERM;
            end
            WAIT_PT: begin
                data_ready_o = 1'b1;
                if (data_valid_i) begin
                    round_d = blk_q == 4'(NB_BLOCKS - 1) ? 4'd0 : 4'd6;
                    state_d = blk_q == 4'(NB_BLOCKS - 1) ? FINAL_PERM : PT_PERM;
                end
            end
            PT_PERM: begin
                state_we_o       = 1'b1;
                xor_begin_data_o = round_q == 4'd6;
                cipher_we_o      = round_q == 4'd6;
                cipher_valid_o   = round_q == 4'd6;
                round_d          = last ? 4'd0 : round_q + 4'd1;
                blk_d            = last ? blk_q + 4'd1 : blk_q;
                state_d          = last ? WAIT_PT : PT_PERM;
            end
            FINAL_PERM: begin
                state_we_o       = 1'b1;
                xor_begin_data_o = round_q == 4'd0;
                xor_begin_key_o  = round_q == 4'd0;
                cipher_we_o      = round_q == 4'd0;
                cipher_valid_o   = round_q == 4'd0;
                xor_end_key_o    = last;
                tag_we_o         = last;
                round_d          = last ? 4'd0 : round_q + 4'd1;
                state_d          = last ? DONE : FINAL_PERM;
            end
            DONE: begin
                end_o       = 1'b1;
                tag_valid_o = 1'b1;
                round_d     = 4'd0;
                state_d     = IDLE;
            end
            default: begin
                round_d = 4'd0;
                blk_d   = 4'd0;
                state_d = IDLE;
            end
        endcase
`ifdef FSM_ENC_ABORT_EN
        if (abort_i && state_q != IDLE) begin
            state_d = IDLE;
            round_d = 4'd0;
            blk_d   = 4'd0;
        end
`endif
    end
endmodule

// File: tb/tb_ascon_fsm_encrypt.sv
// tb_ascon_fsm_encrypt: randomized self-checking bench for ascon_fsm_encrypt (NB_BLOCKS=4 and 1).
// Expected per-cycle output traces are generated from the message phase schedule.
module tb_ascon_fsm_encrypt;
    logic clk = 1'b0, rst = 1'b1, start4 = 1'b0, start1 = 1'b0, valid = 1'b0, abort = 1'b0;
    int total = 0, bad = 0;
    always #5 clk = ~clk;

    logic rdy4, ini4, we4, bd4, bk4, ek4, el4, cwe4, cv4, twe4, tv4, en4;
    logic rdy1, ini1, we1, bd1, bk1, ek1, el1, cwe1, cv1, twe1, tv1, en1;
    logic [3:0] rn4, rn1;
    logic [15:0] obs4, obs1;
    assign obs4 = {rdy4, rn4, ini4, we4, bd4, bk4, ek4, el4, cwe4, cv4, twe4, tv4, en4};
    assign obs1 = {rdy1, rn1, ini1, we1, bd1, bk1, ek1, el1, cwe1, cv1, twe1, tv1, en1};

    ascon_fsm_encrypt #(.NB_BLOCKS(4)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start4), .data_valid_i(valid),
`ifdef FSM_ENC_ABORT_EN
        .abort_i(abort),
`endif
        .data_ready_o(rdy4), .round_o(rn4), .init_state_o(ini4), .state_we_o(we4),
        .xor_begin_data_o(bd4), .xor_begin_key_o(bk4), .xor_end_key_o(ek4), .xor_end_lsb_o(el4),
        .cipher_we_o(cwe4), .cipher_valid_o(cv4), .tag_we_o(twe4), .tag_valid_o(tv4), .end_o(en4));

    ascon_fsm_encrypt #(.NB_BLOCKS(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start1), .data_valid_i(valid),
`ifdef FSM_ENC_ABORT_EN
        .abort_i(abort),
`endif
        .data_ready_o(rdy1), .round_o(rn1), .init_state_o(ini1), .state_we_o(we1),
        .xor_begin_data_o(bd1), .xor_begin_key_o(bk1), .xor_end_key_o(ek1), .xor_end_lsb_o(el1),
        .cipher_we_o(cwe1), .cipher_valid_o(cv1), .tag_we_o(twe1), .tag_valid_o(tv1), .end_o(en1));

    function automatic logic [15:0] mk(bit rdy, int r, bit ini, bit we, bit bd, bit bk, bit ek,
                                       bit el, bit cwe, bit cv, bit twe, bit tv, bit en);
        return {rdy, 4'(r), ini, we, bd, bk, ek, el, cwe, cv, twe, tv, en};
    endfunction

    function automatic logic [15:0] cur(int nb);
        return nb == 1 ? obs1 : obs4;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_msg(input int nb, input int adw, input int ptw_blk, input int ptw, input bit hold);
        logic [15:0] e[$];
        bit v[$];
        logic [15:0] o;
        int endc = 0, cvn = 0, exp_end;
        e.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)); v.push_back(1'($urandom));
        for (int r = 0; r < 12; r++) begin
            e.push_back(mk(0, r, 0, 1, 0, 0, r == 11, 0, 0, 0, 0, 0, 0)); v.push_back(1'($urandom));
        end
        for (int w = 0; w < adw; w++) begin
            e.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); v.push_back(1'b0);
        end
        e.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); v.push_back(1'b1);
        for (int r = 6; r < 12; r++) begin
            e.push_back(mk(0, r, 0, 1, r == 6, 0, 0, r == 11, 0, 0, 0, 0, 0)); v.push_back(1'($urandom));
        end
        for (int b = 0; b < nb; b++) begin
            for (int w = 0; w < (b == ptw_blk ? ptw : 0); w++) begin
                e.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); v.push_back(1'b0);
            end
            e.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); v.push_back(1'b1);
            if (b < nb - 1)
                for (int r = 6; r < 12; r++) begin
                    e.push_back(mk(0, r, 0, 1, r == 6, 0, 0, 0, r == 6, r == 6, 0, 0, 0));
                    v.push_back(1'($urandom));
                end
            else
                for (int r = 0; r < 12; r++) begin
                    e.push_back(mk(0, r, 0, 1, r == 0, r == 0, r == 11, 0, r == 0, r == 0, r == 11, 0, 0));
                    v.push_back(1'($urandom));
                end
        end
        e.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1)); v.push_back(1'($urandom));
        o = cur(nb);
        total++;
        if (o !== 16'h0) begin bad++; $display("FAIL idle_before nb=%0d got=%h exp=0000", nb, o); end
        if (nb == 1) start1 = 1'b1; else start4 = 1'b1;
        step();
        if (!hold) begin start1 = 1'b0; start4 = 1'b0; end
        for (int i = 0; i < e.size(); i++) begin
            o = cur(nb);
            total++;
            if (o !== e[i]) begin
                bad++;
                $display("FAIL trace nb=%0d cycle=%0d got=%h exp=%h", nb, i + 1, o, e[i]);
            end
            if (o[0] === 1'b1 && endc == 0) endc = i + 1;
            if (o[3] === 1'b1) cvn++;
            valid = v[i];
            step();
        end
        o = cur(nb);
        total++;
        if (o !== 16'h0) begin bad++; $display("FAIL idle_after nb=%0d got=%h exp=0000", nb, o); end
        exp_end = 1 + 12 + 1 + adw + 6 + nb + 6 * (nb - 1) + (ptw_blk < nb ? ptw : 0) + 12 + 1;
        total++;
        if (endc != exp_end) begin bad++; $display("FAIL end_cycle nb=%0d got=%0d exp=%0d", nb, endc, exp_end); end
        total++;
        if (cvn != nb) begin bad++; $display("FAIL cipher_count nb=%0d got=%0d exp=%0d", nb, cvn, nb); end
    endtask

    task automatic test_reset();
        rst = 1'b1; valid = 1'b1;
        step(); step();
        total++;
        if (obs4 !== 16'h0 || obs1 !== 16'h0) begin
            bad++; $display("FAIL reset_state got4=%h got1=%h exp=0000", obs4, obs1);
        end
        rst = 1'b0;
    endtask

    task automatic test_baseline();
        run_msg(4, 0, 9, 0, 0);
        run_msg(1, 0, 9, 0, 0);
    endtask

    task automatic test_stall();
        run_msg(4, 5, 1, 3, 0);
        run_msg(1, 2, 0, 4, 0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++)
            run_msg(k % 2 ? 1 : 4, $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 5), 0);
    endtask

    task automatic test_back_to_back();
        run_msg(4, 0, 9, 0, 1);
        run_msg(4, 1, 2, 2, 0);
    endtask

    task automatic test_mid_reset();
        start4 = 1'b1; valid = 1'b1;
        step();
        start4 = 1'b0;
        for (int i = 1; i < 24; i++) step();
        total++;
        if (rn4 !== 4'd8 || cv4 !== 1'b0 || we4 !== 1'b1) begin
            bad++; $display("FAIL pre_reset_round got=%0d exp=8", rn4);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++;
        if (obs4 !== 16'h0) begin bad++; $display("FAIL mid_reset got=%h exp=0000", obs4); end
        run_msg(4, 0, 9, 0, 0);
    endtask

`ifdef FSM_ENC_ABORT_EN
    task automatic test_abort();
        int seen = 0;
        start4 = 1'b1; valid = 1'b1;
        step();
        start4 = 1'b0;
        for (int i = 1; i < 48; i++) step();
        total++;
        if (rn4 !== 4'd5 || we4 !== 1'b1) begin bad++; $display("FAIL pre_abort_round got=%0d exp=5", rn4); end
        abort = 1'b1;
        step();
        abort = 1'b0;
        total++;
        if (obs4 !== 16'h0) begin bad++; $display("FAIL abort_idle got=%h exp=0000", obs4); end
        for (int i = 0; i < 20; i++) begin
            if (twe4 === 1'b1 || en4 === 1'b1 || tv4 === 1'b1) seen++;
            step();
        end
        total++;
        if (seen != 0) begin bad++; $display("FAIL abort_no_tag got=%0d exp=0", seen); end
        abort = 1'b1;
        step();
        abort = 1'b0;
        run_msg(4, 0, 9, 0, 0);
    endtask
`endif

    initial begin
        test_reset();
        test_baseline();
        test_stall();
        test_back_to_back();
        test_mid_reset();
        test_random();
`ifdef FSM_ENC_ABORT_EN
        test_abort();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
